approx_error_sweeper: RTL and testbench

- Hardware error-evaluation stage placed directly downstream of a generated approximate SOP circuit and its exact counterpart.
- Exhaustively drives all 2^N_IN input vectors into both combinational circuits and consumes their outputs.
- Reports the worst-case absolute error, the first input vector that reached it, and the count of vectors whose error exceeds the error threshold ET.
- Used on the bench and on FPGA to confirm that an approximate netlist honours its error threshold.

---
 rtl/approx_eval_pkg.sv | 10 +
 rtl/err_abs_unit.sv | 15 +
 rtl/approx_error_sweeper.sv | 76 +++++++
 tb/tb_approx_error_sweeper.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// approx_eval_pkg: shared sweep state encoding, sizing constants and abs-difference helper
package approx_eval_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  localparam int N_IN_DEF = 4;
  localparam int NUM_VEC = 2 ** N_IN_DEF;
  localparam int CNT_W = N_IN_DEF + 1;
  function automatic int unsigned abs_diff_f(input int unsigned a, input int unsigned b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/err_abs_unit.sv
// err_abs_unit: combinational |a-b| on unsigned operands via a one-bit-wider signed difference
module err_abs_unit #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic signed [W:0] d;
  // the difference of two W-bit unsigned values always fits W+1 signed bits, and its magnitude fits W bits
  always_comb begin
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    y = d[W] ? W'(-d) : d[W-1:0];
  end
endmodule

// File: rtl/approx_error_sweeper.sv
// approx_error_sweeper: exhaustive exact-vs-approximate error sweep; ERR_SUM_EN adds an err_sum output
module approx_error_sweeper
  import approx_eval_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_OUT = 2,
  parameter int unsigned ET = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   in_vec,
  input  logic [N_OUT-1:0]  exact_val,
  input  logic [N_OUT-1:0]  approx_val,
  output logic              busy,
  output logic              done,
  output logic [N_OUT-1:0]  max_err,
  output logic [N_IN-1:0]   worst_vec,
  output logic [N_IN:0]     viol_count,
  output logic              violation
`ifdef ERR_SUM_EN
  , output logic [N_OUT+N_IN-1:0] err_sum
`endif
);
  localparam int NUM_V = 2 ** N_IN;
  state_t state;
  logic [N_IN-1:0] s1_vec;
  logic [N_OUT-1:0] s1_exact, s1_approx, err;
  logic s1_valid, go, last;
  err_abs_unit #(.W(N_OUT)) u_abs (.a(s1_exact), .b(s1_approx), .y(err));
  assign go = state == IDLE && start;
  assign last = &in_vec;
  assign busy = state == SWEEP || state == DRAIN;
  assign done = state == DONE;
  assign violation = viol_count != '0;
  // sweep sequencing, S1 capture of the circuit outputs and S2 statistics update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_vec <= '0;
      s1_valid <= 1'b0;
      s1_vec <= '0;
      s1_exact <= '0;
      s1_approx <= '0;
      max_err <= '0;
      worst_vec <= '0;
      viol_count <= '0;
    end else begin
      state <= go ? SWEEP : state == SWEEP ? (last ? DRAIN : SWEEP) : state == DRAIN ? DONE : IDLE;
      in_vec <= go ? '0 : (state == SWEEP && !last) ? in_vec + 1'b1 : in_vec;
      s1_valid <= state == SWEEP;
      s1_vec <= in_vec;
      s1_exact <= exact_val;
      s1_approx <= approx_val;
      if (go) begin
        max_err <= '0;
        worst_vec <= '0;
        viol_count <= '0;
      end else if (s1_valid) begin
        if (err > max_err) begin
          max_err <= err;
          worst_vec <= s1_vec;
        end
        if (32'(err) > ET && viol_count != (N_IN+1)'(NUM_V)) viol_count <= viol_count + 1'b1;
      end
    end
  end
`ifdef ERR_SUM_EN
  // total error across the sweep; width covers NUM_V * (2^N_OUT - 1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sum <= '0;
    else if (go) err_sum <= '0;
    else if (s1_valid) err_sum <= err_sum + (N_OUT+N_IN)'(err);
  end
`endif
endmodule

// File: tb/tb_approx_error_sweeper.sv
// tb_approx_error_sweeper: randomized and directed sweeps checked by a scoreboard against a table-driven model
module tb_approx_error_sweeper;
  localparam int ET_TB = 2;
  localparam int LAT = 17;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] in_vec, worst_vec;
  logic [1:0] exact_val, approx_val, max_err;
  logic [4:0] viol_count;
  logic busy, done, violation;
`ifdef ERR_SUM_EN
  logic [5:0] err_sum;
`endif
  logic [1:0] ex_t [16];
  logic [1:0] ap_t [16];
  typedef struct {
    int mx;
    int wv;
    int vc;
    int sm;
    int sc;
  } exp_t;
  exp_t sb [$];
  int total = 0, bad = 0, cyc = 0, n_done = 0;

  approx_error_sweeper #(.N_IN(4), .N_OUT(2), .ET(ET_TB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
    .exact_val(exact_val), .approx_val(approx_val), .busy(busy), .done(done),
    .max_err(max_err), .worst_vec(worst_vec), .viol_count(viol_count), .violation(violation)
`ifdef ERR_SUM_EN
    , .err_sum(err_sum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // the two circuits under evaluation are lookup tables driven by in_vec
  always_comb begin
    exact_val = ex_t[in_vec];
    approx_val = ap_t[in_vec];
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("max_err", int'(max_err), e.mx);
        chk("worst_vec", int'(worst_vec), e.wv);
        chk("viol_count", int'(viol_count), e.vc);
        chk("violation", int'(violation), int'(e.vc != 0));
        chk("done_latency", cyc - e.sc, LAT);
        chk("busy_at_done", int'(busy), 0);
`ifdef ERR_SUM_EN
        chk("err_sum", int'(err_sum), e.sm);
`endif
      end
    end
  end

  function automatic exp_t model();
    exp_t e;
    e.mx = 0; e.wv = 0; e.vc = 0; e.sm = 0; e.sc = 0;
    for (int v = 0; v < 16; v++) begin
      int d;
      d = int'(ex_t[v]) - int'(ap_t[v]);
      if (d < 0) d = -d;
      if (d > e.mx) begin
        e.mx = d;
        e.wv = v;
      end
      if (d > ET_TB) e.vc++;
      e.sm += d;
    end
    return e;
  endfunction

  task automatic run_sweep(input bit ign);
    exp_t e;
    bit seen = 1'b0;
    e = model();
    @(negedge clk);
    e.sc = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_sweep", int'(busy), 1);
    if (ign) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end else if (ign) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("idle_not_busy", int'(busy), 0);
    chk("in_vec_hold", int'(in_vec), 15);
  endtask

  task automatic fill_rand();
    for (int v = 0; v < 16; v++) begin
      ex_t[v] = 2'($urandom_range(0, 3));
      ap_t[v] = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int v = 0; v < 16; v++) begin
      ex_t[v] = '0;
      ap_t[v] = '0;
    end
    #1;
    chk("rst_in_vec", int'(in_vec), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_viol_count", int'(viol_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // no error anywhere
    fill_rand();
    for (int v = 0; v < 16; v++) ap_t[v] = ex_t[v];
    run_sweep(1'b0);
    // single full-scale error at vector 9
    ex_t[9] = 2'd0;
    ap_t[9] = 2'd3;
    run_sweep(1'b0);
    // equal errors at 3 and 5: earlier vector wins
    fill_rand();
    for (int v = 0; v < 16; v++) ap_t[v] = ex_t[v];
    ex_t[3] = 2'd2; ap_t[3] = 2'd0;
    ex_t[5] = 2'd0; ap_t[5] = 2'd2;
    run_sweep(1'b0);
    // every vector violates: count reaches 16 without wrapping
    for (int v = 0; v < 16; v++) begin
      ex_t[v] = 2'd3;
      ap_t[v] = 2'd0;
    end
    run_sweep(1'b1);
    run_sweep(1'b0);
    // abort mid-sweep with asynchronous reset
    begin
      exp_t e;
      int sc;
      e = model();
      @(negedge clk);
      sc = cyc + 1;
      e.sc = sc;
      sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && cyc < sc + 8; i++) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("abort_in_vec", int'(in_vec), 0);
      chk("abort_max_err", int'(max_err), 0);
      chk("abort_viol_count", int'(viol_count), 0);
      chk("abort_violation", int'(violation), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
`ifdef ERR_SUM_EN
      chk("abort_err_sum", int'(err_sum), 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
    end
    run_sweep(1'b0);
    // randomized tables, half with stray start pulses
    for (int t = 0; t < 8; t++) begin
      fill_rand();
      run_sweep(t[0]);
    end
    repeat (25) @(negedge clk);
    chk("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
